// File: rtl/kmeans_pkg.sv
// Shared kmeans constants and the assignment-reader state encoding.
package kmeans_pkg;

  localparam int unsigned IO_BRAM_ADDR_SIZE_BITS_NB = 15;
  localparam int unsigned LANES_PER_WORD            = 4;
  localparam int unsigned ID_NB                     = 8;
  localparam int unsigned MAX_NUM_POINTS_NB         = 4096;
  localparam logic [IO_BRAM_ADDR_SIZE_BITS_NB-1:0] FCLUSTER_LADDR = 15'h0400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT
  } rd_state_e;

endpackage

// File: rtl/assignment_stream_reader.sv
// Streams packed 8-bit cluster IDs out of IO BRAM as one valid/ready beat per point.
// First beat 3 cycles after start, 2-cycle bubble per new word; beats hold stable under backpressure.
module assignment_stream_reader #(
  parameter int unsigned IO_ADDR_NB = kmeans_pkg::IO_BRAM_ADDR_SIZE_BITS_NB,
  parameter int unsigned WORD_NB    = 32,
  parameter int unsigned ID_NB      = kmeans_pkg::ID_NB,
  parameter logic [IO_ADDR_NB-1:0] BASE_ADDR = IO_ADDR_NB'(kmeans_pkg::FCLUSTER_LADDR),
  parameter int unsigned MAX_POINTS = kmeans_pkg::MAX_NUM_POINTS_NB
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [15:0]           num_points_i,
  output logic                  ready_o,
  output logic [IO_ADDR_NB-1:0] io_addr_o,
  output logic                  io_we_o,
  input  logic [WORD_NB-1:0]    io_din_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [ID_NB-1:0]      id_o,
  output logic [15:0]           id_idx_o,
  output logic                  id_last_o
);

  import kmeans_pkg::*;

  localparam int unsigned LANE_NB = $clog2(LANES_PER_WORD);
  localparam logic [LANE_NB-1:0] LAST_LANE = LANE_NB'(LANES_PER_WORD - 1);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic [IO_ADDR_NB-1:0] r_addr;
  logic [15:0]           r_idx;
  logic [15:0]           r_n;
  logic [WORD_NB-1:0]    r_buf;
  logic [LANE_NB-1:0]    r_lane;

  logic [15:0] w_n_clamped;
  logic        w_emit;
  logic        w_hs;
  logic        w_last;

  assign w_n_clamped = (num_points_i > 16'(MAX_POINTS)) ? 16'(MAX_POINTS) : num_points_i;
  assign w_emit      = (r_state == ST_EMIT);
  assign w_hs        = w_emit && id_ready_i;
  assign w_last      = (r_idx == (r_n - 16'd1));

  assign ready_o    = (r_state == ST_IDLE);
  assign io_addr_o  = r_addr;
  assign io_we_o    = 1'b0;
  assign id_valid_o = w_emit;
  assign id_o       = w_emit ? r_buf[r_lane*ID_NB +: ID_NB] : '0;
  assign id_idx_o   = r_idx;
  assign id_last_o  = w_emit && w_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_i && (w_n_clamped != 16'd0)) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = ST_WAIT;
      ST_WAIT:  w_state_nxt = ST_EMIT;
      ST_EMIT: begin
        if (w_hs) begin
          if (w_last)                  w_state_nxt = ST_IDLE;
          else if (r_lane == LAST_LANE) w_state_nxt = ST_FETCH;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Address parks at BASE_ADDR whenever idle so the BRAM port is quiet between runs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_addr  <= BASE_ADDR;
      r_idx   <= '0;
      r_n     <= '0;
      r_buf   <= '0;
      r_lane  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start_i && (w_n_clamped != 16'd0)) begin
            r_n    <= w_n_clamped;
            r_addr <= BASE_ADDR;
            r_idx  <= '0;
          end
        end
        ST_WAIT: begin
          r_buf  <= io_din_i;
          r_lane <= '0;
        end
        ST_EMIT: begin
          if (w_hs) begin
            r_idx  <= r_idx + 16'd1;
            r_lane <= r_lane + LANE_NB'(1);
            if (w_last)                   r_addr <= BASE_ADDR;
            else if (r_lane == LAST_LANE) r_addr <= r_addr + IO_ADDR_NB'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
